// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package rr_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam int N_DEF        = 3;
  localparam int MAX_HOLD_DEF = 4;
  localparam int N_MAX        = 8;

  // Wide one-hot; callers narrow the result to their own N with a sized cast.
  function automatic logic [N_MAX-1:0] onehot(input logic [2:0] idx, input int n);
    logic [N_MAX-1:0] v;
    int               i;
    v = '0;
    i = int'(idx);
    if (i < n) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Wrap-around priority search: first set req bit strictly after ptr, modulo N.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          mask_owner,
  output logic          found,
  output logic [PW-1:0] idx
);

  // Walk from the farthest position back to ptr+1 so the nearest hit wins.
  // Position k==N is ptr itself, which mask_owner removes from the search.
  always_comb begin
    int p;
    found = 1'b0;
    idx   = '0;
    p     = 0;
    for (int k = N; k >= 1; k--) begin
      p = 32'(ptr) + k;
      if (p >= N) p = p - N;
      if (req[PW'(p)] && !(mask_owner && (k == N))) begin
        found = 1'b1;
        idx   = PW'(p);
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant with bounded hold time.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         timeout
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [PW-1:0] PTR_RST   = PW'(N - 1);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic          found;
  logic [PW-1:0] pick_idx;
  logic [N-1:0]  pick_oh;

  // While granting, the owner is excluded so expiry hands off to someone else
  // if anyone is waiting; on release its req is already low anyway.
  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req        (req),
    .ptr        (ptr),
    .mask_owner (state == GRANT),
    .found      (found),
    .idx        (pick_idx)
  );

  assign pick_oh = N'(onehot(3'(pick_idx), N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      hold_cnt <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= pick_oh;
            busy     <= 1'b1;
            ptr      <= pick_idx;
            hold_cnt <= '0;
            state    <= GRANT;
          end else begin
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[ptr]) begin
            hold_cnt <= '0;
            if (found) begin
              grant <= pick_oh;
              busy  <= 1'b1;
              ptr   <= pick_idx;
            end else begin
              grant <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (hold_cnt < HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            // Expiry: hand off if someone waits, otherwise restart the owner's window.
            timeout  <= 1'b1;
            hold_cnt <= '0;
            if (found) begin
              grant <= pick_oh;
              ptr   <= pick_idx;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
